// File: rtl/dtc_sched_pkg.sv
// Shared widths and the result record for the decision-tree classifier scheduler.
// Classes fit in 3 bits; requester IDs are sized for the largest supported NREQ (8).
package dtc_sched_pkg;

    localparam int FEAT_W      = 12;
    localparam int CLASS_W     = 3;
    localparam int NUM_CLASSES = 8;
    localparam int STAT_W      = 16;
    localparam int ID_MAX_W    = 3;

    typedef struct packed {
        logic [CLASS_W-1:0]  cls;
        logic [ID_MAX_W-1:0] id;
    } dtc_res_t;

endpackage

// File: rtl/dtc_rr_arb.sv
// Round-robin grant over NREQ requesters, searching from ptr+1; ptr moves only on an accepted grant.
// Latency: combinational grant. Backpressure: caller withholds advance, so ptr holds and grant is recomputed.
// Grant is not latched, so a requester dropping its request loses the grant with no state change.
module dtc_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

    // Reset to the last slot so requester 0 is the first one searched.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (advance) begin
            ptr <= gnt_id;
        end
    end

endmodule

// File: rtl/dtc_sched.sv
// Round-robin scheduler feeding one combinational classifier; two-stage pipeline, results on valid/ready.
// Latency: result valid 2 cycles after request handshake. Backpressure: holds up to 2 vectors, then req_ready all-zero.
// Optional per-class result counters built when DTC_SCHED_STATS_EN is defined; otherwise stat_cnt is 0.
module dtc_sched
    import dtc_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*FEAT_W-1:0] req_inp,
    output logic [NREQ-1:0]        req_ready,
    output logic [FEAT_W-1:0]      tree_inp,
    input  logic [CLASS_W-1:0]     tree_outp,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [CLASS_W-1:0]     res_class,
    output logic [IDW-1:0]         res_id,
    output logic                   busy,
    input  logic [2:0]             stat_sel,
    input  logic                   stat_clr,
    output logic [STAT_W-1:0]      stat_cnt
);

    logic              s1_v;
    logic [FEAT_W-1:0] s1_feat;
    logic [IDW-1:0]    s1_id;
    logic              s2_v;
    dtc_res_t          s2;

    logic              s1_load;
    logic              s2_load;
    logic              hs;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_id;
    logic [FEAT_W-1:0] gnt_feat;
    logic              unused_id;

    assign s2_load   = s1_v && (!s2_v || res_ready);
    assign s1_load   = !s1_v || s2_load;
    assign req_ready = (s1_load && !rst) ? gnt : '0;
    assign hs        = |req_ready;

    dtc_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (hs),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        gnt_feat = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_feat = req_inp[FEAT_W*i +: FEAT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_feat <= '0;
            s1_id   <= '0;
            s2_v    <= 1'b0;
            s2      <= '0;
        end else begin
            if (s1_load) begin
                s1_v <= hs;
            end
            if (hs) begin
                s1_feat <= gnt_feat;
                s1_id   <= gnt_id;
            end
            // A new load wins over the downstream pop, keeping s2_v set.
            if (s2_load) begin
                s2_v   <= 1'b1;
                s2.cls <= tree_outp;
                s2.id  <= ID_MAX_W'(s1_id);
            end else if (res_ready) begin
                s2_v <= 1'b0;
            end
        end
    end

    assign tree_inp  = s1_feat;
    assign res_valid = s2_v;
    assign res_class = s2.cls;
    assign res_id    = s2.id[IDW-1:0];
    assign busy      = s1_v || s2_v;
    assign unused_id = ^s2.id;

`ifdef DTC_SCHED_STATS_EN
    logic [STAT_W-1:0] cnt [NUM_CLASSES];

    // Clear also zeroes the readout so it reads 0 on the very next cycle.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                cnt[c] <= '0;
            end
            stat_cnt <= '0;
        end else begin
            if (s2_v && res_ready && (cnt[s2.cls] != '1)) begin
                cnt[s2.cls] <= cnt[s2.cls] + STAT_W'(1);
            end
            stat_cnt <= cnt[stat_sel];
        end
    end
`else
    logic unused_stat;

    assign unused_stat = ^{stat_sel, stat_clr};
    assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_dtc_sched.sv
// Bench for dtc_sched with a behavioural classifier and a result scoreboard.
module tb_dtc_sched;
    import dtc_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*FEAT_W-1:0] req_inp;
    logic [NREQ-1:0]        req_ready;
    logic [FEAT_W-1:0]      tree_inp;
    logic [CLASS_W-1:0]     tree_outp;
    logic                   res_valid;
    logic                   res_ready;
    logic [CLASS_W-1:0]     res_class;
    logic [IDW-1:0]         res_id;
    logic                   busy;
    logic [2:0]             stat_sel;
    logic                   stat_clr;
    logic [STAT_W-1:0]      stat_cnt;

    int checks   = 0;
    int failures = 0;
    logic [CLASS_W+IDW-1:0] sb [$];

    always #5 clk = ~clk;

    // Reference classifier: all-zero input maps to class 1.
    function automatic logic [CLASS_W-1:0] cls_of(input logic [FEAT_W-1:0] x);
        return x[2:0] ^ x[11:9] ^ 3'b001;
    endfunction

    assign tree_outp = cls_of(tree_inp);

    dtc_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_inp   (req_inp),
        .req_ready (req_ready),
        .tree_inp  (tree_inp),
        .tree_outp (tree_outp),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_id    (res_id),
        .busy      (busy),
        .stat_sel  (stat_sel),
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
    );

    // Scoreboard: push on request handshake, pop and compare on result handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (res_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_result got=%h/%h exp=none", res_class, res_id);
                end else begin
                    logic [CLASS_W+IDW-1:0] exp;
                    exp = sb.pop_front();
                    if ({res_class, res_id} !== exp) begin
                        failures++;
                        $display("FAIL sb_result got=%h exp=%h", {res_class, res_id}, exp);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back({cls_of(req_inp[FEAT_W*i +: FEAT_W]), IDW'(i)});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        to_drive();
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        to_sample();
        to_drive();
        rst = 1'b0;
        to_sample();
    endtask

    task automatic drain();
        to_drive();
        req_valid = '0;
        res_ready = 1'b1;
        to_sample();
        for (int k = 0; k < 10 && busy; k++) begin
            to_drive();
            to_sample();
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout busy got=%b exp=0", busy);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_lost_results got=%0d pending exp=0", sb.size());
        end
    endtask

    task automatic test_reset();
        to_drive();
        rst = 1'b1;
        req_valid = '1;
        req_inp = {$urandom, $urandom};
        to_sample();
        checks++;
        if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (tree_inp !== '0) begin failures++; $display("FAIL reset_tree_inp got=%h exp=0", tree_inp); end
        checks++;
        if ({res_class, res_id} !== '0) begin
            failures++;
            $display("FAIL reset_res got=%h/%h exp=0/0", res_class, res_id);
        end
        checks++;
        if (stat_cnt !== '0) begin failures++; $display("FAIL reset_stat_cnt got=%h exp=0", stat_cnt); end
        to_drive();
        rst = 1'b0;
        req_valid = '0;
        to_sample();
    endtask

    task automatic test_single();
        do_reset();
        to_drive();
        req_valid = 4'b0100;
        req_inp = '0;
        res_ready = 1'b1;
        to_sample();
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_req_ready got=%b exp=0100", req_ready); end
        to_drive();
        req_valid = '0;
        to_sample();
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", res_valid); end
        to_drive();
        to_sample();
        checks++;
        if ({res_valid, res_class, res_id} !== {1'b1, 3'b001, 2'd2}) begin
            failures++;
            $display("FAIL single_result got=%b/%h/%h exp=1/1/2", res_valid, res_class, res_id);
        end
        to_drive();
        to_sample();
        checks++;
        if ({res_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL single_idle got=%b%b exp=00", res_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_gnt;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            to_drive();
            req_valid = '1;
            res_ready = 1'b1;
            req_inp = {$urandom, $urandom};
            to_sample();
            exp_gnt = '0;
            exp_gnt[i % NREQ] = 1'b1;
            checks++;
            if (req_ready !== exp_gnt) begin
                failures++;
                $display("FAIL rr_grant cycle=%0d got=%b exp=%b", i, req_ready, exp_gnt);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int hs_cnt;
        logic [FEAT_W-1:0] v0;
        hs_cnt = 0;
        v0 = '0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            to_drive();
            req_valid = 4'b0011;
            res_ready = 1'b0;
            req_inp = {$urandom, $urandom};
            if (i == 0) v0 = req_inp[FEAT_W-1:0];
            to_sample();
            if (|(req_valid & req_ready)) hs_cnt++;
            if (i == 0) begin
                checks++;
                if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_first_grant got=%b exp=0001", req_ready); end
            end
            if (i >= 2) begin
                checks++;
                if ({res_valid, res_class, res_id} !== {1'b1, cls_of(v0), 2'd0}) begin
                    failures++;
                    $display("FAIL bp_hold cycle=%0d got=%b/%h/%h exp=1/%h/0", i, res_valid, res_class, res_id, cls_of(v0));
                end
            end
        end
        checks++;
        if (req_ready !== '0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", req_ready); end
        checks++;
        if (hs_cnt != 2) begin failures++; $display("FAIL bp_handshakes got=%0d exp=2", hs_cnt); end
        for (int i = 0; i < 4; i++) begin
            to_drive();
            res_ready = 1'b1;
            req_inp = {$urandom, $urandom};
            to_sample();
        end
        drain();
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            to_drive();
            req_valid = 4'b0001;
            res_ready = 1'b0;
            req_inp = {$urandom, $urandom};
            to_sample();
        end
        checks++;
        if ({busy, res_valid, req_ready} !== {2'b11, 4'b0000}) begin
            failures++;
            $display("FAIL midrst_full got=%b%b/%b exp=11/0000", busy, res_valid, req_ready);
        end
        to_drive();
        rst = 1'b1;
        req_valid = '1;
        to_sample();
        to_drive();
        rst = 1'b0;
        res_ready = 1'b1;
        to_sample();
        checks++;
        if ({res_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL midrst_flush got=%b%b exp=00", res_valid, busy);
        end
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_ptr got=%b exp=0001", req_ready); end
        drain();
    endtask

`ifdef DTC_SCHED_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            to_drive();
            req_valid = '1;
            req_inp = '0;
            res_ready = 1'b1;
            to_sample();
        end
        drain();
        to_drive();
        stat_sel = 3'd1;
        to_sample();
        to_drive();
        to_sample();
        checks++;
        if (stat_cnt !== 16'hFFFF) begin failures++; $display("FAIL stats_saturate got=%h exp=ffff", stat_cnt); end
        to_drive();
        stat_sel = 3'd0;
        to_sample();
        to_drive();
        to_sample();
        checks++;
        if (stat_cnt !== 16'h0000) begin failures++; $display("FAIL stats_other_class got=%h exp=0", stat_cnt); end
        to_drive();
        stat_sel = 3'd1;
        stat_clr = 1'b1;
        to_sample();
        to_drive();
        stat_clr = 1'b0;
        to_sample();
        checks++;
        if (stat_cnt !== 16'h0000) begin failures++; $display("FAIL stats_clear got=%h exp=0", stat_cnt); end
        for (int i = 0; i < 3; i++) begin
            to_drive();
            req_valid = 4'b0001;
            req_inp = {NREQ{12'h004}};
            to_sample();
        end
        drain();
        to_drive();
        stat_sel = 3'd5;
        to_sample();
        to_drive();
        to_sample();
        checks++;
        if (stat_cnt !== 16'd3) begin failures++; $display("FAIL stats_count got=%h exp=3", stat_cnt); end
    endtask
`else
    task automatic test_stats();
        for (int s = 0; s < 8; s++) begin
            to_drive();
            stat_sel = 3'(s);
            stat_clr = s[0];
            req_valid = '1;
            res_ready = 1'b1;
            req_inp = '0;
            to_sample();
            checks++;
            if (stat_cnt !== '0) begin failures++; $display("FAIL stats_disabled sel=%0d got=%h exp=0", s, stat_cnt); end
        end
        drain();
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_inp = '0;
        res_ready = 1'b1;
        stat_sel = '0;
        stat_clr = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mid_reset();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
